minicube_move_engine: RTL

- Successor to the 2x2 mini-cube keyboard input block.
- Decodes PS/2 make/break scancode pairs into face turns and applies them to a 24-sticker cube state of parametrised colour width.
- Adds an undo history, an LFSR-driven multi-move scramble, a move counter and a solved flag.
- Sits between the PS/2 receiver and the cube display renderer.

---
 rtl/minicube_move_engine.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/minicube_move_engine.sv
// 2x2 mini-cube move engine: decodes PS/2 break codes into face turns and keeps
// the 24-sticker state, with undo history, LFSR scramble, move counter and solved flag.
module minicube_move_engine #(
  parameter int          CW           = 3,
  parameter int          HIST_DEPTH   = 8,
  parameter int          SCRAMBLE_LEN = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   key,
  input  logic                          key_stb,
  output logic [24*CW-1:0]              dat,
  output logic                          move_done,
  output logic                          busy,
  output logic                          solved,
  output logic [15:0]                   move_cnt,
  output logic [$clog2(HIST_DEPTH):0]   hist_cnt
);

  localparam int HW = $clog2(HIST_DEPTH);
  localparam int DW = 24 * CW;

  typedef enum logic {IDLE, SCRAM} state_e;
  typedef enum logic [1:0] {CMD_TURN, CMD_RESET, CMD_UNDO} cmd_e;

  function automatic logic [CW-1:0] home_colour(input int k);
    int j;
    if (k < 4)  return CW'(1);
    if (k >= 20) return CW'(6);
    j = (k >= 12) ? k - 8 : k;
    return CW'(5 - (j - 4) / 2);
  endfunction

  function automatic logic [DW-1:0] home_state();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 24; k++) r[CW*k +: CW] = home_colour(k);
    return r;
  endfunction

  localparam logic [DW-1:0] HOME = home_state();

  // Move codes 0..2 are Q,W,E; 3..5 are their inverses (source/destination swapped).
  function automatic logic [DW-1:0] turn(input logic [DW-1:0] s, input logic [2:0] mv);
    int dst[12];
    int src[12];
    logic [DW-1:0] r;
    case (mv)
      3'd0, 3'd3: begin
        dst = '{7, 15, 14, 6, 3, 2, 16, 8, 20, 21, 5, 13};
        src = '{15, 14, 6, 7, 16, 8, 20, 21, 5, 13, 3, 2};
      end
      3'd1, 3'd4: begin
        dst = '{0, 1, 3, 2, 11, 10, 9, 8, 7, 6, 5, 4};
        src = '{1, 3, 2, 0, 9, 8, 7, 6, 5, 4, 11, 10};
      end
      default: begin
        dst = '{8, 9, 17, 16, 3, 1, 10, 18, 23, 21, 15, 7};
        src = '{9, 17, 16, 8, 10, 18, 23, 21, 15, 7, 3, 1};
      end
    endcase
    r = s;
    for (int i = 0; i < 12; i++) begin
      if (mv < 3'd3) r[CW*dst[i] +: CW] = s[CW*src[i] +: CW];
      else           r[CW*src[i] +: CW] = s[CW*dst[i] +: CW];
    end
    return r;
  endfunction

  function automatic logic [2:0] inverse(input logic [2:0] mv);
    return (mv < 3'd3) ? mv + 3'd3 : mv - 3'd3;
  endfunction

  function automatic logic is_solved(input logic [DW-1:0] s);
    int grp[6][4];
    logic ok;
    grp = '{'{0, 1, 2, 3}, '{4, 5, 12, 13}, '{6, 7, 14, 15},
            '{8, 9, 16, 17}, '{10, 11, 18, 19}, '{20, 21, 22, 23}};
    ok = 1'b1;
    for (int g = 0; g < 6; g++)
      for (int i = 1; i < 4; i++)
        if (s[CW*grp[g][i] +: CW] != s[CW*grp[g][0] +: CW]) ok = 1'b0;
    return ok;
  endfunction

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic            cmd_vld_q, cmd_vld_d;
  logic [2:0]      mv_q, mv_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_nxt;
  logic [DW-1:0]   dat_q, dat_d;
  logic            move_done_q, move_done_d;
  logic            solved_q;
  logic [15:0]     mcnt_q, mcnt_d;
  logic [HW:0]     hcnt_q, hcnt_d;
  logic [HW-1:0]   wp_q, wp_d, wp_prev;
  logic            hist_we;
  logic [2:0]      scr_mv;
  logic [2:0]      hist_q [HIST_DEPTH];

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_vld_d   = 1'b0;
    mv_d        = mv_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    dat_d       = dat_q;
    move_done_d = 1'b0;
    mcnt_d      = mcnt_q;
    hcnt_d      = hcnt_q;
    wp_d        = wp_q;
    hist_we     = 1'b0;
    wp_prev     = wp_q - HW'(1);
    lfsr_nxt    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    scr_mv      = (lfsr_nxt[2:0] >= 3'd6) ? lfsr_nxt[2:0] - 3'd6 : lfsr_nxt[2:0];

    case (state_q)
      IDLE: begin
        // Execute the command registered on the previous edge.
        if (cmd_vld_q) begin
          case (cmd_q)
            CMD_TURN: begin
              dat_d       = turn(dat_q, mv_q);
              move_done_d = 1'b1;
              hist_we     = 1'b1;
              wp_d        = wp_q + HW'(1);
              if (hcnt_q != (HW+1)'(HIST_DEPTH)) hcnt_d = hcnt_q + (HW+1)'(1);
              if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
            end
            CMD_UNDO: begin
              if (hcnt_q != '0) begin
                dat_d       = turn(dat_q, inverse(hist_q[wp_prev]));
                move_done_d = 1'b1;
                wp_d        = wp_prev;
                hcnt_d      = hcnt_q - (HW+1)'(1);
                if (mcnt_q != 16'd0) mcnt_d = mcnt_q - 16'd1;
              end
            end
            default: begin
              dat_d       = HOME;
              move_done_d = 1'b1;
              mcnt_d      = '0;
              hcnt_d      = '0;
            end
          endcase
        end
        if (key_stb && key[15:8] == 8'hF0) begin
          case (key[7:0])
            8'h15: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd0; end
            8'h1D: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd1; end
            8'h24: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd2; end
            8'h1C: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd3; end
            8'h1B: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd4; end
            8'h23: begin cmd_vld_d = 1'b1; cmd_d = CMD_TURN; mv_d = 3'd5; end
            8'h2B: begin cmd_vld_d = 1'b1; cmd_d = CMD_RESET; end
            8'h3C: begin cmd_vld_d = 1'b1; cmd_d = CMD_UNDO; end
            8'h2D: begin state_d = SCRAM; cnt_d = 8'(SCRAMBLE_LEN); end
            default: ;
          endcase
        end
      end
      SCRAM: begin
        lfsr_d      = lfsr_nxt;
        dat_d       = turn(dat_q, scr_mv);
        move_done_d = 1'b1;
        cnt_d       = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          hcnt_d  = '0;
          mcnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_TURN;
      cmd_vld_q   <= 1'b0;
      mv_q        <= '0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      dat_q       <= HOME;
      move_done_q <= 1'b0;
      solved_q    <= 1'b1;
      mcnt_q      <= '0;
      hcnt_q      <= '0;
      wp_q        <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_vld_q   <= cmd_vld_d;
      mv_q        <= mv_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      dat_q       <= dat_d;
      move_done_q <= move_done_d;
      solved_q    <= is_solved(dat_q);
      mcnt_q      <= mcnt_d;
      hcnt_q      <= hcnt_d;
      wp_q        <= wp_d;
      if (hist_we) hist_q[wp_q] <= mv_q;
    end
  end

  assign dat       = dat_q;
  assign move_done = move_done_q;
  assign busy      = (state_q == SCRAM);
  assign solved    = solved_q;
  assign move_cnt  = mcnt_q;
  assign hist_cnt  = hcnt_q;

endmodule
